// File: rtl/rpi_frame_capture.sv
`timescale 1ns/1ps
// rpi_frame_capture: recovers the Raspberry Pi 1-bit video stream by
// oversampling on clk, packs 8 pixels per byte (first pixel in the MSB) and
// writes each frame into asynchronous SRAM through a 4-cycle write engine.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   rpi_h_sync          RPi hsync (async, active-low)
//   rpi_v_sync          RPi vsync (async, active-low)
//   rpi_color           RPi pixel data (async, 1 = lit)
//   sram_addr           SRAM byte address
//   sram_data           SRAM write data
//   sram_we_n           SRAM write enable, active-low
//   frame_done          one-cycle pulse once the last byte of a frame is written
//   line_err            one-cycle pulse when hsync cuts a line short
module rpi_frame_capture #(
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned H_SKIP     = 0,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rpi_h_sync,
    input  logic              rpi_v_sync,
    input  logic              rpi_color,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_data,
    output logic              sram_we_n,
    output logic              frame_done,
    output logic              line_err
);

    localparam int unsigned DIV_W          = $clog2(SAMPLE_DIV);
    localparam int unsigned SKIP_W         = (H_SKIP > 0) ? $clog2(H_SKIP + 1) : 1;
    localparam int unsigned X_W            = $clog2(H_ACTIVE + 1);
    localparam int unsigned Y_W            = $clog2(V_ACTIVE + 1);
    localparam int unsigned BYTES_PER_LINE = H_ACTIVE / 8;
    localparam int unsigned DIV_MID        = SAMPLE_DIV / 2;
    localparam int unsigned DIV_LAST       = SAMPLE_DIV - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_LINE
    } state_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_W0,
        WR_W1,
        WR_W2,
        WR_W3
    } wr_state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detectors
    // ------------------------------------------------------------------
    logic [1:0] h_pipe;
    logic [1:0] v_pipe;
    logic [1:0] c_pipe;
    logic       h_prev;
    logic       v_prev;
    logic       c_dly;
    logic       h_rise;
    logic       h_fall;
    logic       v_fall;

    // Sync pipes idle high; color gets one extra stage to stay aligned with the edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_pipe <= 2'b11;
            v_pipe <= 2'b11;
            c_pipe <= 2'b11;
            h_prev <= 1'b1;
            v_prev <= 1'b1;
            c_dly  <= 1'b1;
            h_rise <= 1'b0;
            h_fall <= 1'b0;
            v_fall <= 1'b0;
        end else begin
            h_pipe <= {h_pipe[0], rpi_h_sync};
            v_pipe <= {v_pipe[0], rpi_v_sync};
            c_pipe <= {c_pipe[0], rpi_color};
            h_prev <= h_pipe[1];
            v_prev <= v_pipe[1];
            c_dly  <= c_pipe[1];
            h_rise <= h_pipe[1] & ~h_prev;
            h_fall <= ~h_pipe[1] & h_prev;
            v_fall <= ~v_pipe[1] & v_prev;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM, datapath and write engine state
    // ------------------------------------------------------------------
    state_t              state,     state_nxt;
    logic [DIV_W-1:0]    div,       div_nxt;
    logic [SKIP_W-1:0]   skip_cnt,  skip_nxt;
    logic [X_W-1:0]      x,         x_nxt;
    logic [Y_W-1:0]      y,         y_nxt;
    logic [ADDR_W-1:0]   line_base, base_nxt;
    logic [6:0]          shift,     shift_nxt;
    wr_state_t           wr_st,     wr_st_nxt;
    logic                done_pend, done_pend_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [7:0]          data_nxt;
    logic                we_n_nxt;
    logic                frame_done_nxt;
    logic                line_err_nxt;

    logic [7:0]          wr_byte;
    logic                wr_start;
    logic                line_end;
    logic                resync;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            div        <= '0;
            skip_cnt   <= '0;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            shift      <= '0;
            wr_st      <= WR_IDLE;
            done_pend  <= 1'b0;
            sram_addr  <= '0;
            sram_data  <= '0;
            sram_we_n  <= 1'b1;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            div        <= div_nxt;
            skip_cnt   <= skip_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            line_base  <= base_nxt;
            shift      <= shift_nxt;
            wr_st      <= wr_st_nxt;
            done_pend  <= done_pend_nxt;
            sram_addr  <= addr_nxt;
            sram_data  <= data_nxt;
            sram_we_n  <= we_n_nxt;
            frame_done <= frame_done_nxt;
            line_err   <= line_err_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nxt      = state;
        div_nxt        = div;
        skip_nxt       = skip_cnt;
        x_nxt          = x;
        y_nxt          = y;
        base_nxt       = line_base;
        shift_nxt      = shift;
        wr_st_nxt      = wr_st;
        done_pend_nxt  = done_pend;
        addr_nxt       = sram_addr;
        data_nxt       = sram_data;
        we_n_nxt       = 1'b1;
        frame_done_nxt = 1'b0;
        line_err_nxt   = 1'b0;
        wr_byte        = {shift, c_dly};
        wr_start       = 1'b0;
        line_end       = 1'b0;
        resync         = 1'b0;

        // A finished frame is reported only after its last write has retired.
        if (done_pend && (wr_st == WR_W3 || wr_st == WR_IDLE)) begin
            frame_done_nxt = 1'b1;
            done_pend_nxt  = 1'b0;
        end

        // Capture FSM; vsync is checked first so it wins over hsync.
        case (state)
            ST_IDLE: begin
                if (v_fall) begin
                    resync = 1'b1;
                end
            end
            ST_ARM: begin
                if (v_fall) begin
                    resync = 1'b1;
                end else if (h_rise) begin
                    state_nxt = ST_LINE;
                    div_nxt   = '0;
                    skip_nxt  = '0;
                    x_nxt     = '0;
                end
            end
            ST_LINE: begin
                if (v_fall) begin
                    resync = 1'b1;
                end else if (h_fall) begin
                    line_err_nxt = 1'b1;
                    line_end     = 1'b1;
                end else begin
                    div_nxt = (div == DIV_W'(DIV_LAST)) ? '0 : div + DIV_W'(1);
                    if (div == DIV_W'(DIV_LAST) && skip_cnt != SKIP_W'(H_SKIP)) begin
                        skip_nxt = skip_cnt + SKIP_W'(1);
                    end
                    // Mid-pixel sample once the back porch has been skipped.
                    if (skip_cnt == SKIP_W'(H_SKIP) && div == DIV_W'(DIV_MID)) begin
                        shift_nxt = wr_byte[6:0];
                        x_nxt     = x + X_W'(1);
                        if (x[2:0] == 3'd7) begin
                            wr_start = 1'b1;
                        end
                        if (x == X_W'(H_ACTIVE - 1)) begin
                            line_end = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Start of frame or resynchronisation: partial byte is dropped.
        if (resync) begin
            state_nxt = ST_ARM;
            y_nxt     = '0;
            base_nxt  = '0;
            shift_nxt = '0;
        end

        // Full or truncated line both advance to the next line slot.
        if (line_end) begin
            base_nxt = line_base + ADDR_W'(BYTES_PER_LINE);
            y_nxt    = y + Y_W'(1);
            if (y == Y_W'(V_ACTIVE - 1)) begin
                state_nxt     = ST_IDLE;
                done_pend_nxt = 1'b1;
            end else begin
                state_nxt = ST_ARM;
            end
        end

        // Write engine: W0 setup, W1/W2 strobe, W3 hold.
        case (wr_st)
            WR_W0: begin
                wr_st_nxt = WR_W1;
                we_n_nxt  = 1'b0;
            end
            WR_W1: begin
                wr_st_nxt = WR_W2;
                we_n_nxt  = 1'b0;
            end
            WR_W2: begin
                wr_st_nxt = WR_W3;
            end
            WR_W3: begin
                wr_st_nxt = WR_IDLE;
            end
            default: begin
                wr_st_nxt = WR_IDLE;
            end
        endcase

        // Byte spacing guarantees the engine is idle here; x still holds the pre-increment count.
        if (wr_start) begin
            wr_st_nxt = WR_W0;
            addr_nxt  = line_base + ADDR_W'(x >> 3);
            data_nxt  = wr_byte;
        end
    end

endmodule

// File: tb/tb_rpi_frame_capture.sv
`timescale 1ns/1ps
// Scoreboard bench for rpi_frame_capture: a line/byte-level reference model
// queues expected SRAM writes and frame/line events; a monitor compares.
module tb_rpi_frame_capture;

    localparam int unsigned SD = 4;
    localparam int unsigned HS = 0;
    localparam int unsigned HA = 16;
    localparam int unsigned VA = 2;
    localparam int unsigned AW = 16;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          h     = 1'b1;
    logic          v     = 1'b1;
    logic          c     = 1'b0;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_data;
    logic          sram_we_n;
    logic          frame_done;
    logic          line_err;

    rpi_frame_capture #(
        .SAMPLE_DIV (SD),
        .H_SKIP     (HS),
        .H_ACTIVE   (HA),
        .V_ACTIVE   (VA),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rpi_h_sync (h),
        .rpi_v_sync (v),
        .rpi_color  (c),
        .sram_addr  (sram_addr),
        .sram_data  (sram_data),
        .sram_we_n  (sram_we_n),
        .frame_done (frame_done),
        .line_err   (line_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_exp_t;

    typedef struct {
        int          kind;
        int unsigned wr_before;
        bit          timed;
    } ev_exp_t;

    wr_exp_t     wq[$];
    ev_exp_t     eq[$];
    int unsigned n_vec       = 0;
    int unsigned n_mis       = 0;
    int unsigned writes_done = 0;
    int unsigned wr_pushed   = 0;
    bit          mon_en      = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_vec++;
        if (act != req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_mis++;
        $display("FAIL %s: DUT produced an event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // ------------------------------------------------------------------
    // Reference model: frame/line bookkeeping in whole bytes
    // ------------------------------------------------------------------
    int unsigned m_y    = 0;
    int unsigned m_base = 0;
    bit          m_on   = 1'b0;

    function automatic void m_vsync();
        m_y    = 0;
        m_base = 0;
        m_on   = 1'b1;
    endfunction

    // pix holds pixel k at bit HA-1-k; n pixels captured; abort = line ended by vsync.
    function automatic void m_line(input logic [HA-1:0] pix, input int unsigned n, input bit abort);
        logic [HA-1:0] sh;
        if (!m_on) return;
        for (int unsigned b = 0; b < n / 8; b++) begin
            sh = pix << (8 * b);
            wq.push_back('{addr: m_base + b, data: 32'(sh[HA-1 -: 8])});
            wr_pushed++;
        end
        if (abort) return;
        if (n < HA) eq.push_back('{kind: EV_ERR, wr_before: wr_pushed, timed: 1'b0});
        m_base += HA / 8;
        m_y++;
        if (m_y == VA) begin
            eq.push_back('{kind: EV_DONE, wr_before: wr_pushed, timed: (n == HA)});
            m_on = 1'b0;
        end
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic vsync_pulse();
        m_vsync();
        v = 1'b0;
        repeat (8) @(negedge clk);
        v = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic drive_line(input logic [HA-1:0] pix, input int unsigned n, input bit abort);
        m_line(pix, n, abort);
        h = 1'b0;
        repeat (8) @(negedge clk);
        h = 1'b1;
        @(negedge clk);
        for (int unsigned k = 0; k < n; k++) begin
            c = pix[HA-1-k];
            repeat (SD) @(negedge clk);
        end
        c = 1'b0;
        if (abort) return;
        if (n < HA) h = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && (wq.size() != 0 || eq.size() != 0); i++) @(negedge clk);
        check("write_queue_drained", wq.size(), 0);
        check("event_queue_drained", eq.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        bit          prev_we   = 1'b1;
        int unsigned low       = 0;
        int unsigned a0        = 0;
        int unsigned d0        = 0;
        int unsigned last_rise = 0;
        wr_exp_t     we;
        ev_exp_t     ee;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_we = 1'b1;
                low     = 0;
                continue;
            end
            if (!sram_we_n) begin
                if (prev_we) begin
                    a0 = 32'(sram_addr);
                    d0 = 32'(sram_data);
                end
                low++;
            end else if (!prev_we) begin
                check("we_low_cycles", low, 2);
                check("addr_held_w3", 32'(sram_addr), a0);
                check("data_held_w3", 32'(sram_data), d0);
                if (wq.size() == 0) begin
                    unexpected("write");
                end else begin
                    we = wq.pop_front();
                    check("write_addr", a0, we.addr);
                    check("write_data", d0, we.data);
                end
                writes_done++;
                last_rise = cyc;
                low       = 0;
            end
            prev_we = sram_we_n;

            if (line_err) begin
                if (eq.size() == 0) begin
                    unexpected("line_err");
                end else begin
                    ee = eq.pop_front();
                    check("line_err_kind", 32'(EV_ERR), 32'(ee.kind));
                end
            end
            if (frame_done) begin
                if (eq.size() == 0) begin
                    unexpected("frame_done");
                end else begin
                    ee = eq.pop_front();
                    check("frame_done_kind", 32'(EV_DONE), 32'(ee.kind));
                    check("frame_done_after_writes", writes_done, ee.wr_before);
                    if (ee.timed) check("frame_done_latency", cyc - last_rise, 1);
                end
            end
        end
    end

    // Hang guard
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [HA-1:0] pix;
        int unsigned   mode;
        int unsigned   n;
        bit            aborted;

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            h = 1'($urandom);
            v = 1'($urandom);
            c = 1'($urandom);
        end
        check("reset_we_n", 32'(sram_we_n), 1);
        check("reset_addr", 32'(sram_addr), 0);
        check("reset_data", 32'(sram_data), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        check("reset_line_err", 32'(line_err), 0);
        h = 1'b1;
        v = 1'b1;
        c = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_no_writes", writes_done, 0);

        // Single frame, fixed pattern
        vsync_pulse();
        drive_line(16'hA50F, HA, 1'b0);
        drive_line(16'hFF00, HA, 1'b0);
        repeat (20) @(negedge clk);
        check("pattern_frame_writes", writes_done, 4);

        // Short line: cut after 12 pixels
        vsync_pulse();
        drive_line(16'h5A3C, 12, 1'b0);
        drive_line(16'h1234, HA, 1'b0);
        repeat (20) @(negedge clk);

        // Mid-frame vsync after 8 pixels of line1, then a full frame
        vsync_pulse();
        drive_line(16'hC3E7, HA, 1'b0);
        drive_line(16'h9966, 8, 1'b1);
        vsync_pulse();
        drive_line(16'h0FF0, HA, 1'b0);
        drive_line(16'h8001, HA, 1'b0);
        repeat (20) @(negedge clk);

        // Back-to-back all-ones frames
        repeat (2) begin
            vsync_pulse();
            drive_line(16'hFFFF, HA, 1'b0);
            drive_line(16'hFFFF, HA, 1'b0);
        end
        repeat (20) @(negedge clk);

        // Randomized frames: full, truncated and vsync-aborted lines
        for (int f = 0; f < 14; f++) begin
            vsync_pulse();
            aborted = 1'b0;
            for (int unsigned l = 0; l < VA; l++) begin
                pix  = HA'($urandom);
                mode = $urandom_range(0, 5);
                if (mode == 0) begin
                    n = $urandom_range(1, HA - 1);
                    drive_line(pix, n, 1'b0);
                end else if (mode == 1) begin
                    n = $urandom_range(1, HA - 1);
                    drive_line(pix, n, 1'b1);
                    aborted = 1'b1;
                    break;
                end else begin
                    drive_line(pix, HA, 1'b0);
                end
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
            // Extra line after the frame must be ignored.
            if (!aborted && $urandom_range(0, 3) == 0) drive_line(HA'($urandom), HA, 1'b0);
        end
        drain();

        // Reset in the middle of a write
        mon_en = 1'b0;
        vsync_pulse();
        m_on = 1'b0;
        h = 1'b0;
        repeat (8) @(negedge clk);
        h = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            c = 1'($urandom);
            repeat (SD) @(negedge clk);
        end
        c = 1'b0;
        for (int i = 0; i < 40 && sram_we_n; i++) @(negedge clk);
        check("we_low_before_reset", 32'(sram_we_n), 0);
        #2 rst_n = 1'b0;
        #1;
        check("we_n_async_reset", 32'(sram_we_n), 1);
        check("addr_async_reset", 32'(sram_addr), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/rpi_frame_capture.md
# rpi_frame_capture

Capture stage that sits directly upstream of the SRAM-backed VGA output path. It samples the Raspberry Pi's 1-bit video (`rpi_color`) in the `clk` domain, using `rpi_h_sync`/`rpi_v_sync` for framing. It packs 8 pixels per byte and writes each frame into external asynchronous SRAM for the display stage to read back. The RPi pixel clock is deliberately not used; pixels are recovered by oversampling on `clk`.

## Interface
- `SAMPLE_DIV`, 4: `clk` cycles per RPi pixel; must be ≥ 2.
- `H_SKIP`, 0: pixel periods ignored after hsync deasserts (back porch).
- `H_ACTIVE`, 640: captured pixels per line; must be a multiple of 8.
- `V_ACTIVE`, 480: captured lines per frame.
- `ADDR_W`, 16: SRAM byte-address width; must satisfy H_ACTIVE*V_ACTIVE/8 ≤ 2^ADDR_W.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rpi_h_sync` in 1: RPi hsync, asynchronous, active-low.
- `rpi_v_sync` in 1: RPi vsync, asynchronous, active-low.
- `rpi_color` in 1: RPi pixel data, asynchronous; 1 = lit.
- `sram_addr` out ADDR_W: SRAM byte address.
- `sram_data` out 8: SRAM write data; first pixel of the byte is in the MSB.
- `sram_we_n` out 1: SRAM write enable, active-low.
- `frame_done` out 1: one-cycle pulse after the last byte of a frame is written.
- `line_err` out 1: one-cycle pulse when a line is cut short by hsync.

## Operation
- All three RPi inputs pass through 2-FF synchronizers, then a 1-cycle edge detector on each sync. "Edge" below means the registered, synchronized signal.
- The capture FSM has three states: IDLE, ARM and LINE.
- IDLE:
  - On vsync falling edge: set y=0, line_base=0, and go to ARM.
- ARM:
  - On hsync rising edge (sync end): clear the div counter and pixel counter x, and go to LINE.
- LINE:
  - The div counter runs 0..SAMPLE_DIV-1 and wraps.
  - The first H_SKIP wraps are discarded.
  - After that, the pixel is sampled when div == SAMPLE_DIV/2 (integer division, mid-pixel). The sample is shifted into an 8-bit register MSB-first and x increments.
  - Every 8th sample, the byte is handed to the write engine at address line_base + (x-1)/8.
  - When x == H_ACTIVE: set line_base += H_ACTIVE/8 and y++. If y becomes V_ACTIVE, pulse `frame_done` once the final write completes and go to IDLE; otherwise go to ARM.
- Write engine, independent of the FSM; each write takes 4 cycles:
  - W0: drive addr/data, `sram_we_n`=1.
  - W1, W2: `sram_we_n`=0.
  - W3: `sram_we_n`=1 with addr/data held.
  - Byte spacing is ≥ 8*SAMPLE_DIV ≥ 16 cycles, so the engine can never be busy when a new byte arrives. No queue is required.
- Boundary conditions:
  - **vsync falling edge in ARM or LINE:** resynchronise. Discard the partial byte, set y=0 and line_base=0, and go to ARM. An in-flight write completes. No `frame_done` pulse.
  - **hsync falling edge in LINE before x == H_ACTIVE:** pulse `line_err` and discard the partial byte. Advance line_base and y as for a full line, then go to ARM. If y reaches V_ACTIVE, go to IDLE and still pulse `frame_done`.
  - **vsync and hsync edges in the same cycle:** vsync wins.
  - **Reset mid-write:** `sram_we_n` returns to 1 immediately (asynchronous).
- Reset values: `sram_we_n`=1, `sram_addr`=0, `sram_data`=0, `frame_done`=0, `line_err`=0, FSM=IDLE, all counters 0, synchronizer flops 1 (sync idle-high).

## Timing
- Input to edge-detect output: 3 cycles.
- If the hsync rising edge is detected in cycle T, pixel k (0-based, after skip) is sampled in cycle T+1+(H_SKIP+k)*SAMPLE_DIV+SAMPLE_DIV/2.
- The write engine enters W0 in the cycle after the 8th sample of a byte. `sram_we_n` is low in W0+1 and W0+2.
- `frame_done` is asserted in the cycle after W3 of the last byte.
- `line_err` is asserted in the cycle after the offending hsync edge is detected.

## Test plan
All scenarios use SAMPLE_DIV=4, H_SKIP=0, H_ACTIVE=16, V_ACTIVE=2.
- **Reset:** hold `rst_n`=0 with random inputs -> `sram_we_n`=1, all outputs 0; release, no syncs applied -> no writes.
- **Single frame, pattern:** line0 = 0xA5,0x0F and line1 = 0xFF,0x00 -> exactly 4 writes: addr0=0xA5, addr1=0x0F, addr2=0xFF, addr3=0x00. Each write has `sram_we_n` low for exactly 2 cycles. `frame_done` pulses once.
- **Short line:** hsync reasserts after 12 pixels of line0 -> one write (addr0), `line_err` pulse; line1 bytes land at addr2/addr3.
- **Mid-frame vsync:** vsync falls after 8 pixels of line1 -> the in-flight write completes, no `frame_done`; the next frame rewrites from addr0.
- **Back-to-back frames:** two frames of all-ones -> 8 writes of 0xFF (addr0..3 twice), 2 `frame_done` pulses, no `line_err`.
